// File: rtl/relu_grad_gate.sv
`default_nettype none
// ============================================================================
//  Module      : relu_grad_gate
//  Description : Backward-pass gate for a ReLU stage. Forward samples push one
//                sign-mask bit each into a FIFO; backward gradients pop the
//                bits in the same order and pass through where the forward
//                input was non-negative, else emit zero. 1-cycle latency,
//                full throughput, output register stable under backpressure.
//  Revision    : 1.0  initial release
// ============================================================================
module relu_grad_gate #(
  parameter  int featureWidth = 16,
  parameter  int gradWidth    = 16,
  parameter  int DEPTH        = 64,
  localparam int ADDR_W       = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    clear,
  input  logic                    fwd_valid,
  output logic                    fwd_ready,
  input  logic [featureWidth-1:0] fwd_x,
  input  logic                    grad_in_valid,
  output logic                    grad_in_ready,
  input  logic [gradWidth-1:0]    grad_in,
  output logic                    grad_out_valid,
  input  logic                    grad_out_ready,
  output logic [gradWidth-1:0]    grad_out,
  output logic [ADDR_W:0]         mask_count
);

  localparam logic [ADDR_W:0]   c_FULL    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   c_CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_PTR_ONE = ADDR_W'(1);

  logic [DEPTH-1:0]     r_mask;
  logic [ADDR_W-1:0]    r_wr_ptr;
  logic [ADDR_W-1:0]    r_rd_ptr;
  logic [ADDR_W:0]      r_count;
  logic                 r_out_valid;
  logic [gradWidth-1:0] r_out_data;

  logic                 w_fwd_ready;
  logic                 w_grad_in_ready;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_rd_bit;
  logic [gradWidth-1:0] w_gated;
  logic                 w_unused_x;

  // Only the sign bit of the forward sample matters for the mask.
  assign w_unused_x = ^fwd_x[featureWidth-2:0];

  // Full/empty come from the registered count only, so there is no bypass
  // in either direction; clear blocks every transfer in its cycle.
  assign w_fwd_ready     = enable & (r_count != c_FULL);
  assign w_grad_in_ready = enable & (r_count != '0) & (~r_out_valid | grad_out_ready);
  assign w_push          = fwd_valid & w_fwd_ready & ~clear;
  assign w_pop           = grad_in_valid & w_grad_in_ready & ~clear;
  assign w_rd_bit        = r_mask[r_rd_ptr];
  assign w_gated         = w_rd_bit ? grad_in : '0;

  assign fwd_ready      = w_fwd_ready;
  assign grad_in_ready  = w_grad_in_ready;
  assign grad_out_valid = r_out_valid;
  assign grad_out       = r_out_data;
  assign mask_count     = r_count;

  // Mask storage: a set bit means the forward input was non-negative.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '0;
    end else if (w_push) begin
      r_mask[r_wr_ptr] <= ~fwd_x[featureWidth-1];
    end
  end

  // Pointers wrap naturally (DEPTH is a power of 2); count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output register: loads on accept, drains on downstream ready, otherwise
  // holds its value regardless of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (clear) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_gated;
    end else if (grad_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_relu_grad_gate.sv
`default_nettype none
// ============================================================================
//  Module      : tb_relu_grad_gate
//  Description : Scoreboard bench for relu_grad_gate. A queue-based model of
//                the mask FIFO predicts each gated gradient; a monitor pops
//                and compares whenever the DUT hands off an output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_relu_grad_gate;

  localparam int FW    = 16;
  localparam int GW    = 16;
  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          clear;
  logic          fwd_valid;
  logic          fwd_ready;
  logic [FW-1:0] fwd_x;
  logic          grad_in_valid;
  logic          grad_in_ready;
  logic [GW-1:0] grad_in;
  logic          grad_out_valid;
  logic          grad_out_ready;
  logic [GW-1:0] grad_out;
  logic [AW:0]   mask_count;

  bit mask_q[$];
  int exp_q[$];
  bit exp_valid;
  int n_checks;
  int n_fail;

  always #5 clk = ~clk;

  relu_grad_gate #(
    .featureWidth(FW),
    .gradWidth   (GW),
    .DEPTH       (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .clear         (clear),
    .fwd_valid     (fwd_valid),
    .fwd_ready     (fwd_ready),
    .fwd_x         (fwd_x),
    .grad_in_valid (grad_in_valid),
    .grad_in_ready (grad_in_ready),
    .grad_in       (grad_in),
    .grad_out_valid(grad_out_valid),
    .grad_out_ready(grad_out_ready),
    .grad_out      (grad_out),
    .mask_count    (mask_count)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rnd16();
    logic signed [15:0] t;
    t = 16'($urandom);
    return int'(t);
  endfunction

  // One clock of stimulus: drive at negedge, check model-predicted status
  // just before the rising edge, then advance the model by what transfers.
  task automatic cycle(input bit en, input bit clr, input bit fv, input int x,
                       input bit gv, input int g, input bit ordy);
    bit exp_fr;
    bit exp_gr;
    bit push;
    bit pop;
    bit m;
    @(negedge clk);
    enable         = en;
    clear          = clr;
    fwd_valid      = fv;
    fwd_x          = x[FW-1:0];
    grad_in_valid  = gv;
    grad_in        = g[GW-1:0];
    grad_out_ready = ordy;
    #4;
    exp_fr = en && (mask_q.size() != DEPTH);
    exp_gr = en && (mask_q.size() != 0) && (!exp_valid || ordy);
    check("fwd_ready", int'(fwd_ready), int'(exp_fr));
    check("grad_in_ready", int'(grad_in_ready), int'(exp_gr));
    check("mask_count", int'(mask_count), mask_q.size());
    check("grad_out_valid", int'(grad_out_valid), int'(exp_valid));
    push = fv && exp_fr && !clr;
    pop  = gv && exp_gr && !clr;
    if (clr) begin
      mask_q.delete();
      exp_q.delete();
      exp_valid = 1'b0;
    end else begin
      if (pop) begin
        m = mask_q.pop_front();
        exp_q.push_back(m ? g : 0);
      end
      if (push) mask_q.push_back(x >= 0);
      if (pop)       exp_valid = 1'b1;
      else if (ordy) exp_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 1);
  endtask

  // Asynchronous reset asserted in the middle of a clock phase.
  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_grad_out_valid", int'(grad_out_valid), 0);
    check("rst_mask_count", int'(mask_count), 0);
    check("rst_grad_out", int'(grad_out), 0);
    mask_q.delete();
    exp_q.delete();
    exp_valid     = 1'b0;
    enable        = 1'b1;
    clear         = 1'b0;
    fwd_valid     = 1'b0;
    grad_in_valid = 1'b0;
    #1;
    check("rst_fwd_ready", int'(fwd_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare each handed-off output against the scoreboard and make
  // sure a stalled output does not change.
  initial begin
    bit hold;
    int held;
    hold = 1'b0;
    held = 0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n || clear) begin
        hold = 1'b0;
      end else begin
        if (hold && grad_out_valid)
          check("grad_out_stable", int'($signed(grad_out)), held);
        if (grad_out_valid && grad_out_ready) begin
          if (exp_q.size() == 0) check("grad_out_spurious", 1, 0);
          else check("grad_out", int'($signed(grad_out)), exp_q.pop_front());
          hold = 1'b0;
        end else if (grad_out_valid) begin
          hold = 1'b1;
          held = int'($signed(grad_out));
        end else begin
          hold = 1'b0;
        end
      end
    end
  end

  initial begin
    int xs[4];
    int gs[4];
    xs = '{5, -3, 0, -32768};
    gs = '{100, 200, -7, 9};
    n_checks       = 0;
    n_fail         = 0;
    exp_valid      = 1'b0;
    rst_n          = 1'b0;
    enable         = 1'b0;
    clear          = 1'b0;
    fwd_valid      = 1'b0;
    fwd_x          = '0;
    grad_in_valid  = 1'b0;
    grad_in        = '0;
    grad_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Post-reset state and basic sign gating.
    idle(1);
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, xs[i], 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 1, gs[i], 1);
    idle(2);

    // Fill to full, push+pop at full, then drain with pointer wrap.
    for (int i = 0; i < DEPTH + 2; i++) cycle(1, 0, 1, rnd16(), 0, 0, 1);
    cycle(1, 0, 1, 7, 1, rnd16(), 1);
    for (int i = 0; i < DEPTH + 2; i++) cycle(1, 0, 0, 0, 1, rnd16(), 1);
    idle(2);

    // Empty FIFO refuses gradients; a written bit is poppable next cycle.
    cycle(1, 0, 0, 0, 1, 55, 1);
    cycle(1, 0, 1, 1, 1, 55, 1);
    cycle(1, 0, 0, 0, 1, 55, 1);
    idle(2);

    // Backpressure for 3 cycles, then release.
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, rnd16(), 0, 0, 1);
    cycle(1, 0, 0, 0, 1, rnd16(), 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1, rnd16(), 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 1, rnd16(), 1);
    idle(2);

    // Freeze with valids high; output drains while frozen.
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, rnd16(), 0, 0, 1);
    cycle(1, 0, 0, 0, 1, rnd16(), 0);
    cycle(0, 0, 1, rnd16(), 1, rnd16(), 0);
    cycle(0, 0, 1, rnd16(), 1, rnd16(), 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1, rnd16(), 1);
    idle(2);

    // Clear with stored masks and a pending output.
    for (int i = 0; i < 11; i++) cycle(1, 0, 1, rnd16(), 0, 0, 1);
    cycle(1, 0, 0, 0, 1, rnd16(), 0);
    cycle(1, 1, 1, rnd16(), 1, rnd16(), 0);
    idle(2);

    // Reset in the middle of traffic.
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, rnd16(), 0, 0, 1);
    cycle(1, 0, 0, 0, 1, rnd16(), 0);
    async_reset();
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(99) < 90, $urandom_range(299) == 0,
            $urandom_range(99) < 55, rnd16(),
            $urandom_range(99) < 60, rnd16(),
            $urandom_range(99) < 70);

    // Drain and confirm the scoreboard emptied.
    for (int i = 0; i < DEPTH + 4; i++) cycle(1, 0, 0, 0, 1, rnd16(), 1);
    idle(3);
    check("drain_scoreboard_empty", exp_q.size(), 0);
    check("drain_mask_count", int'(mask_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
